sensor_frame_reader: RTL and testbench

- Downstream consumer of the sensor trigger (SENCLK-style 1 Hz strobe).
- On each trigger rising edge, generates a pixel clock to the x-ray sensor for one frame.
- Shifts in the sensor's serial data MSB-first and assembles fixed-width pixel words.
- Presents words on a one-deep valid/ready output. Backpressure stalls the pixel clock, so no data is lost.

---
 rtl/sensor_frame_reader_if.sv | 24 ++
 rtl/sensor_frame_reader.sv | 162 ++++++++++++++++
 tb/tb_sensor_frame_reader.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_frame_reader_if.sv
// Pixel word output channel of sensor_frame_reader: one-deep valid/ready
// handshake. Ports: data/valid/last driven by master, ready by slave.
interface sensor_frame_reader_if #(
    parameter int PIX_BITS = 12
) ();
    logic [PIX_BITS-1:0] data;
    logic                valid;
    logic                ready;
    logic                last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/sensor_frame_reader.sv
// Reads one frame of serial pixel data from the x-ray sensor per trigger edge.
// Ports: i_clk, i_rst (sync, active high), i_trig (async level), i_sdata,
// o_pclk (pixel clock), o_busy, o_frame_done, pix (valid/ready word output).
module sensor_frame_reader #(
    parameter int DIV           = 2048,
    parameter int PIX_BITS      = 12,
    parameter int PIX_PER_FRAME = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_trig,
    input  logic                   i_sdata,
    output logic                   o_pclk,
    output logic                   o_busy,
    output logic                   o_frame_done,
    sensor_frame_reader_if.master  pix
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(PIX_BITS);
    localparam int PW = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;

    localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_M1 = BW'(PIX_BITS - 1);
    localparam logic [PW-1:0] PIX_M1 = PW'(PIX_PER_FRAME - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_XFER,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_div;
    logic [BW-1:0]       r_bit;
    logic [PW-1:0]       r_pix;
    logic [PIX_BITS-1:0] r_shift;
    logic [PIX_BITS-1:0] r_data;
    logic                r_valid;
    logic                r_last;
    logic                r_pclk;
    logic                r_busy;
    logic                r_done;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_hist;
    logic [1:0]          r_settle;
    logic                r_armed;

    logic w_edge;
    logic w_hs;
    logic w_free;

    // r_armed stays low until the synchronizer has refilled after reset and
    // shown TRIG low, so a level held high across reset cannot start a frame.
    assign w_edge = r_sync2 & ~r_hist & r_armed;
    assign w_hs   = r_valid & pix.ready;
    assign w_free = ~r_valid | pix.ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_pix    <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_pclk   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_hist   <= 1'b0;
            r_settle <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_sync1  <= i_trig;
            r_sync2  <= r_sync1;
            r_hist   <= r_sync2;
            r_settle <= {r_settle[0], 1'b1};
            if (r_settle[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            r_done <= 1'b0;

            // Accepted word leaves the slot; a load below overrides this.
            if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_pclk <= 1'b0;
                    if (w_edge) begin
                        r_state <= S_LOW;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_pix   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_div == DIV_M1) begin
                        r_div   <= '0;
                        r_shift <= {r_shift[PIX_BITS-2:0], i_sdata};
                        r_pclk  <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                S_HIGH: begin
                    if (r_div == DIV_M1) begin
                        r_div  <= '0;
                        r_pclk <= 1'b0;
                        if (r_bit != BIT_M1) begin
                            r_bit   <= r_bit + BW'(1);
                            r_state <= S_LOW;
                        end else begin
                            r_state <= S_XFER;
                        end
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                S_XFER: begin
                    if (w_free) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                        r_last  <= (r_pix == PIX_M1);
                        if (r_pix != PIX_M1) begin
                            r_pix   <= r_pix + PW'(1);
                            r_bit   <= '0;
                            r_state <= S_LOW;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_pclk       = r_pclk;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign pix.data     = r_data;
    assign pix.valid    = r_valid;
    assign pix.last     = r_last;
endmodule

// File: tb/tb_sensor_frame_reader.sv
// Testbench for sensor_frame_reader: sensor model, consumer with selectable
// backpressure, and per-scenario checks against words the sensor was given.
module tb_sensor_frame_reader;
    localparam int DIV = 2;
    localparam int PB  = 4;
    localparam int PPF = 3;

    logic clk = 1'b0;
    logic rst;
    logic trig;
    logic sdata;
    logic pclk;
    logic busy;
    logic fdone;

    sensor_frame_reader_if #(.PIX_BITS(PB)) pif ();

    sensor_frame_reader #(
        .DIV(DIV),
        .PIX_BITS(PB),
        .PIX_PER_FRAME(PPF)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_trig(trig),
        .i_sdata(sdata),
        .o_pclk(pclk),
        .o_busy(busy),
        .o_frame_done(fdone),
        .pix(pif.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Stimulus state owned by the initial block
    logic [PB-1:0] sens_words [PPF];
    int rdy_mode = 0;
    int clr_seq = 0;

    // Observations owned by the monitor
    int clr_seen = 0;
    int cyc = 0;
    int rises = 0;
    int fd_cnt = 0;
    int stab_err = 0;
    int busy_cyc = 0;
    int rise_cyc[$];
    logic [PB-1:0] got_w[$];
    logic got_l[$];
    logic prev_pclk = 1'b0;
    logic prev_busy = 1'b0;
    logic st_v = 1'b0;
    logic [PB-1:0] st_d;
    logic st_l;

    // Sensor + consumer model, acting on falling edges only.
    always @(negedge clk) begin
        logic r;
        logic [PB-1:0] w;
        cyc++;
        if (clr_seen != clr_seq) begin
            clr_seen = clr_seq;
            rises = 0;
            fd_cnt = 0;
            stab_err = 0;
            rise_cyc.delete();
            got_w.delete();
            got_l.delete();
        end
        if (pclk === 1'b1 && prev_pclk === 1'b0) begin
            rises++;
            rise_cyc.push_back(cyc);
        end
        prev_pclk = pclk;
        if (busy === 1'b1 && prev_busy === 1'b0) busy_cyc = cyc;
        prev_busy = busy;
        if (fdone === 1'b1) fd_cnt++;
        if (st_v && !rst) begin
            if (pif.valid !== 1'b1 || pif.data !== st_d || pif.last !== st_l)
                stab_err++;
        end
        case (rdy_mode)
            0: r = 1'b1;
            1: r = 1'b0;
            2: r = ~pif.ready;
            default: r = 1'($urandom_range(0, 1));
        endcase
        pif.ready = r;
        if (pif.valid === 1'b1 && r) begin
            got_w.push_back(pif.data);
            got_l.push_back(pif.last);
        end
        st_v = (pif.valid === 1'b1) && !r;
        st_d = pif.data;
        st_l = pif.last;
        // MSB-first: bit for the next PCLK rising edge
        if (rises < PB * PPF) begin
            w = sens_words[rises / PB];
            sdata = w[PB - 1 - (rises % PB)];
        end else begin
            sdata = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_frame();
        trig = 1'b0;
        step(4);
        clr_seq++;
        step(1);
        trig = 1'b1;
    endtask

    task automatic wait_rises(input int n, output bit to);
        int k = 0;
        while (rises < n && k < 1000) begin
            step(1);
            k++;
        end
        to = (rises < n);
    endtask

    task automatic wait_done(output bit to);
        int k = 0;
        while (fd_cnt == 0 && k < 3000) begin
            step(1);
            k++;
        end
        to = (fd_cnt == 0);
        step(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trig = 1'b1;
        step(2);
        n_chk++;
        if ({pclk, busy, fdone, pif.valid, pif.last} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 00000",
                     {pclk, busy, fdone, pif.valid, pif.last});
        end
        n_chk++;
        if (pif.data !== '0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", pif.data);
        end
        rst = 1'b0;
        clr_seq++;
        step(50);
        n_chk++;
        if (rises !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_trig_held rises %0d busy %b want 0 0",
                     rises, busy);
        end
    endtask

    task automatic test_basic();
        bit to;
        sens_words = '{4'hA, 4'h6, 4'hF};
        rdy_mode = 0;
        start_frame();
        wait_done(to);
        n_chk++;
        if (to) begin
            n_fail++;
            $display("FAIL basic_timeout got no frame_done want 1");
        end
        n_chk++;
        if (rises !== PB * PPF) begin
            n_fail++;
            $display("FAIL basic_edges got %0d want %0d", rises, PB * PPF);
        end
        if (rise_cyc.size() >= 2) begin
            n_chk++;
            if (rise_cyc[1] - rise_cyc[0] !== 2 * DIV) begin
                n_fail++;
                $display("FAIL basic_period got %0d want %0d",
                         rise_cyc[1] - rise_cyc[0], 2 * DIV);
            end
            n_chk++;
            if (rise_cyc[0] - busy_cyc !== DIV) begin
                n_fail++;
                $display("FAIL basic_first_edge got %0d want %0d",
                         rise_cyc[0] - busy_cyc, DIV);
            end
        end
        n_chk++;
        if (got_w.size() !== PPF) begin
            n_fail++;
            $display("FAIL basic_count got %0d want %0d", got_w.size(), PPF);
        end
        for (int i = 0; i < PPF && i < got_w.size(); i++) begin
            n_chk++;
            if (got_w[i] !== sens_words[i] || got_l[i] !== (i == PPF - 1)) begin
                n_fail++;
                $display("FAIL basic_word%0d got %h/%b want %h/%b", i,
                         got_w[i], got_l[i], sens_words[i], i == PPF - 1);
            end
        end
        n_chk++;
        if (fd_cnt !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done fd %0d busy %b want 1 0", fd_cnt, busy);
        end
    endtask

    task automatic test_stall();
        bit to;
        int r0;
        int hi = 0;
        sens_words = '{4'hA, 4'h6, 4'hF};
        rdy_mode = 1;
        start_frame();
        wait_rises(2 * PB, to);
        step(4);
        r0 = rises;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (pclk !== 1'b0) hi++;
        end
        n_chk++;
        if (to || rises !== r0 || r0 !== 2 * PB || hi !== 0) begin
            n_fail++;
            $display("FAIL stall_pclk rises %0d->%0d high %0d want %0d->%0d 0",
                     r0, rises, hi, 2 * PB, 2 * PB);
        end
        n_chk++;
        if (pif.valid !== 1'b1 || pif.data !== 4'hA || pif.last !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold got %b/%h/%b want 1/a/0",
                     pif.valid, pif.data, pif.last);
        end
        rdy_mode = 0;
        wait_done(to);
        n_chk++;
        if (to || got_w.size() !== PPF) begin
            n_fail++;
            $display("FAIL stall_count got %0d want %0d", got_w.size(), PPF);
        end
        for (int i = 0; i < PPF && i < got_w.size(); i++) begin
            n_chk++;
            if (got_w[i] !== sens_words[i] || got_l[i] !== (i == PPF - 1)) begin
                n_fail++;
                $display("FAIL stall_word%0d got %h/%b want %h/%b", i,
                         got_w[i], got_l[i], sens_words[i], i == PPF - 1);
            end
        end
        n_chk++;
        if (stab_err !== 0 || rises !== PB * PPF) begin
            n_fail++;
            $display("FAIL stall_stable errs %0d edges %0d want 0 %0d",
                     stab_err, rises, PB * PPF);
        end
    endtask

    task automatic test_retrigger();
        bit to;
        bit to2;
        for (int i = 0; i < PPF; i++) sens_words[i] = PB'($urandom);
        rdy_mode = 0;
        start_frame();
        wait_rises(5, to);
        trig = 1'b0;
        step(4);
        trig = 1'b1;
        wait_done(to2);
        step(60);
        n_chk++;
        if (to || to2 || fd_cnt !== 1 || got_w.size() !== PPF) begin
            n_fail++;
            $display("FAIL retrig fd %0d words %0d want 1 %0d",
                     fd_cnt, got_w.size(), PPF);
        end
        n_chk++;
        if (rises !== PB * PPF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL retrig_edges got %0d busy %b want %0d 0",
                     rises, busy, PB * PPF);
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        sens_words = '{4'hA, 4'h6, 4'hF};
        rdy_mode = 0;
        start_frame();
        wait_rises(6, to);
        rst = 1'b1;
        step(1);
        n_chk++;
        if (to || {pclk, busy, pif.valid, pif.last} !== 4'b0 || pif.data !== '0) begin
            n_fail++;
            $display("FAIL midrst_outs got %b/%h want 0000/0",
                     {pclk, busy, pif.valid, pif.last}, pif.data);
        end
        rst = 1'b0;
        step(2);
        n_chk++;
        if (fd_cnt !== 0) begin
            n_fail++;
            $display("FAIL midrst_nodone got %0d want 0", fd_cnt);
        end
        sens_words = '{4'hC, 4'h1, 4'h3};
        start_frame();
        wait_done(to);
        n_chk++;
        if (to || got_w.size() !== PPF || fd_cnt !== 1) begin
            n_fail++;
            $display("FAIL midrst_count got %0d fd %0d want %0d 1",
                     got_w.size(), fd_cnt, PPF);
        end
        for (int i = 0; i < PPF && i < got_w.size(); i++) begin
            n_chk++;
            if (got_w[i] !== sens_words[i] || got_l[i] !== (i == PPF - 1)) begin
                n_fail++;
                $display("FAIL midrst_word%0d got %h/%b want %h/%b", i,
                         got_w[i], got_l[i], sens_words[i], i == PPF - 1);
            end
        end
    endtask

    task automatic test_backpressure(input int mode, input int frames);
        bit to;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < PPF; i++) sens_words[i] = PB'($urandom);
            rdy_mode = mode;
            start_frame();
            wait_done(to);
            n_chk++;
            if (to || got_w.size() !== PPF || fd_cnt !== 1) begin
                n_fail++;
                $display("FAIL bp%0d_f%0d_count got %0d fd %0d want %0d 1",
                         mode, f, got_w.size(), fd_cnt, PPF);
            end
            for (int i = 0; i < PPF && i < got_w.size(); i++) begin
                n_chk++;
                if (got_w[i] !== sens_words[i] || got_l[i] !== (i == PPF - 1)) begin
                    n_fail++;
                    $display("FAIL bp%0d_f%0d_word%0d got %h/%b want %h/%b",
                             mode, f, i, got_w[i], got_l[i],
                             sens_words[i], i == PPF - 1);
                end
            end
            n_chk++;
            if (stab_err !== 0 || rises !== PB * PPF) begin
                n_fail++;
                $display("FAIL bp%0d_f%0d_stable errs %0d edges %0d want 0 %0d",
                         mode, f, stab_err, rises, PB * PPF);
            end
        end
    endtask

    initial begin
        sens_words = '{4'h0, 4'h0, 4'h0};
        rst = 1'b1;
        trig = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_retrigger();
        test_reset_midframe();
        test_backpressure(2, 2);
        test_backpressure(3, 4);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
